// File: rtl/alu_cmd_ctrl_pkg.sv
// Shared ALU definitions: function codes, default widths, controller state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_cmd_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int OP_WIDTH_DEF   = 4;

  // ALU function codes; 4'hF is reserved as "no operation" on the command side.
  typedef enum logic [3:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_MULT  = 4'h2,
    OP_DIV   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_NAND  = 4'h6,
    OP_NOR   = 4'h7,
    OP_XOR   = 4'h8,
    OP_XNOR  = 4'h9,
    OP_CMPEQ = 4'hA,
    OP_CMPGT = 4'hB,
    OP_CMPLT = 4'hC,
    OP_SHR   = 4'hD,
    OP_SHL   = 4'hE,
    OP_NOP   = 4'hF
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUN,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_SEND_LO,
    ST_SEND_HI
  } ctrl_state_e;

endpackage

// File: rtl/alu_cmd_ctrl_ser.sv
// Result register plus two-beat serializer: returns the 2*DATA_WIDTH result low byte first.
// Latency: tx_vld rises the cycle after load; one byte per cycle with ready held high.
// Backpressure: tx_vld/tx_dat hold until tx_rdy; load is only pulsed while idle.
module alu_result_ser #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [2*DATA_WIDTH-1:0] res_in,
  input  logic                    tx_rdy,
  output logic                    tx_vld,
  output logic [DATA_WIDTH-1:0]   tx_dat,
  output logic                    lo_done,
  output logic                    hi_done
);

  logic [2*DATA_WIDTH-1:0] res_q, res_d;
  logic                    vld_q, vld_d;
  logic                    hi_q,  hi_d;
  logic                    hs;

  assign hs      = vld_q & tx_rdy;
  assign lo_done = hs & ~hi_q;
  assign hi_done = hs & hi_q;
  assign tx_vld  = vld_q;
  assign tx_dat  = hi_q ? res_q[2*DATA_WIDTH-1:DATA_WIDTH] : res_q[DATA_WIDTH-1:0];

  // Capture a fresh result, then step lo -> hi -> idle on each accepted beat.
  always_comb begin
    res_d = res_q;
    vld_d = vld_q;
    hi_d  = hi_q;
    if (load) begin
      res_d = res_in;
      vld_d = 1'b1;
      hi_d  = 1'b0;
    end else if (hs) begin
      if (hi_q) begin
        vld_d = 1'b0;
        hi_d  = 1'b0;
      end else begin
        hi_d  = 1'b1;
      end
    end
  end

  // Result and beat-tracking registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
      vld_q <= 1'b0;
      hi_q  <= 1'b0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      hi_q  <= hi_d;
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command-side ALU controller: builds A/B/FUN frames from RX bytes, issues one op, returns result lo/hi.
// Latency: FUN byte in cycle n -> ALU_EN n+1, result expected n+2, TX lo from n+3, hi n+4.
// Backpressure: TX holds on !TX_READY; RX bytes arriving while busy are dropped (OVERRUN). Macro ALU_CTRL_TIMEOUT_EN adds a result watchdog.
module alu_cmd_ctrl
  import alu_cmd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int OP_WIDTH       = OP_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  output logic [DATA_WIDTH-1:0]   ALU_A,
  output logic [DATA_WIDTH-1:0]   ALU_B,
  output logic [OP_WIDTH-1:0]     ALU_FUN,
  output logic                    ALU_EN,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_Valid,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD,
  input  logic                    TX_READY,
  output logic                    BUSY,
  output logic                    OVERRUN,
  output logic                    TIMEOUT_ERR
);

  ctrl_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OP_WIDTH-1:0]   fun_q, fun_d;
  logic                  en_q, en_d;
  logic                  ovr_q, ovr_d;
  logic                  capture;
  logic                  timeout_hit;
  logic                  lo_done, hi_done;

  assign ALU_A   = a_q;
  assign ALU_B   = b_q;
  assign ALU_FUN = fun_q;
  assign ALU_EN  = en_q;
  assign OVERRUN = ovr_q;
  assign BUSY    = (state_q != ST_GET_A);

  // Frame assembly, issue and result handoff; any byte outside the three GET states is dropped.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    fun_d   = fun_q;
    en_d    = 1'b0;
    ovr_d   = ovr_q;
    capture = 1'b0;
    case (state_q)
      ST_GET_A: if (RX_D_VLD) begin
        a_d     = RX_P_DATA;
        state_d = ST_GET_B;
      end
      ST_GET_B: if (RX_D_VLD) begin
        b_d     = RX_P_DATA;
        state_d = ST_GET_FUN;
      end
      ST_GET_FUN: if (RX_D_VLD) begin
        fun_d = RX_P_DATA[OP_WIDTH-1:0];
        if (RX_P_DATA[OP_WIDTH-1:0] == OP_WIDTH'(OP_NOP)) begin
          state_d = ST_GET_A;
        end else begin
          state_d = ST_ISSUE;
          en_d    = 1'b1;
        end
      end
      ST_ISSUE:    state_d = ST_WAIT_RES;
      ST_WAIT_RES: begin
        if (ALU_OUT_Valid) begin
          capture = 1'b1;
          state_d = ST_SEND_LO;
        end else if (timeout_hit) begin
          state_d = ST_GET_A;
        end
      end
      ST_SEND_LO:  if (lo_done) state_d = ST_SEND_HI;
      ST_SEND_HI:  if (hi_done) state_d = ST_GET_A;
      default:     state_d = ST_GET_A;
    endcase
    if (RX_D_VLD && (state_q != ST_GET_A) && (state_q != ST_GET_B) && (state_q != ST_GET_FUN)) begin
      ovr_d = 1'b1;
    end
  end

  // Controller state and registered command outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_GET_A;
      a_q     <= '0;
      b_q     <= '0;
      fun_q   <= '0;
      en_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      fun_q   <= fun_d;
      en_q    <= en_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef ALU_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  // A valid result in the last counted cycle takes priority over the abort.
  assign timeout_hit = (state_q == ST_WAIT_RES) && !ALU_OUT_Valid &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign TIMEOUT_ERR = tmo_q;

  // Count cycles spent waiting for the ALU; the count restarts on every new wait.
  always_comb begin
    cnt_d = '0;
    tmo_d = tmo_q;
    if (state_q == ST_WAIT_RES && !ALU_OUT_Valid) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end
    if (timeout_hit) begin
      tmo_d = 1'b1;
    end
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`else
  // No watchdog: WAIT_RES holds until the ALU answers (or RST).
  if (TIMEOUT_CYCLES > 0) begin : g_no_wdog
    assign timeout_hit = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
  end else begin : g_no_wdog_degenerate
    assign timeout_hit = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
  end
`endif

  alu_result_ser #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk     (CLK),
    .rst     (RST),
    .load    (capture),
    .res_in  (ALU_OUT),
    .tx_rdy  (TX_READY),
    .tx_vld  (TX_D_VLD),
    .tx_dat  (TX_P_DATA),
    .lo_done (lo_done),
    .hi_done (hi_done)
  );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl: directed frames, a reference ALU answering ALU_EN, and a TX scoreboard.
// Latency: checks pinned to the n+1 / n+3 / n+4 / n+5 frame timeline.
// Backpressure: TX_READY is held low in places to exercise hold and overrun behaviour.
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  ALU_A, ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_Valid;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_READY;
  logic        BUSY, OVERRUN, TIMEOUT_ERR;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int  exp_en = 0;
  int  seen_en = 0;
  bit  alu_resp_en = 1'b1;

  always #5 CLK = ~CLK;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY),
    .BUSY(BUSY), .OVERRUN(OVERRUN), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  function automatic logic [15:0] ref_alu(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      4'h0:    return 16'(a) + 16'(b);
      4'h1:    return 16'(a) - 16'(b);
      4'h2:    return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  // Sends A, B, FUN on consecutive cycles; returns at the start of cycle n+1.
  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input bit expect_tx);
    logic [15:0] r;
    send(a);
    send(b);
    if (f[3:0] != 4'hF) begin
      exp_en++;
      if (expect_tx) begin
        r = ref_alu(f[3:0], a, b);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(r[15:8]);
      end
    end
    send(f);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((BUSY || exp_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL %s actual=busy_after_60_cycles required=idle", name);
    end
  endtask

  // Reference ALU: answers each ALU_EN with a one-cycle valid in the following cycle.
  initial begin
    logic [15:0] r;
    ALU_OUT       = 16'h0;
    ALU_OUT_Valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (ALU_EN && alu_resp_en && !RST) begin
        r = ref_alu(ALU_FUN, ALU_A, ALU_B);
        @(posedge CLK); #1;
        ALU_OUT       = r;
        ALU_OUT_Valid = 1'b1;
        @(posedge CLK); #1;
        ALU_OUT_Valid = 1'b0;
      end
    end
  end

  // Scoreboard: every accepted TX byte must match the next expected byte; held bytes must not move.
  initial begin
    bit         hold = 1'b0;
    logic [7:0] held = 8'h0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        hold = 1'b0;
      end else begin
        if (ALU_EN) seen_en++;
        if (hold) begin
          chk("tx_hold_vld", 32'(TX_D_VLD), 32'd1);
          chk("tx_hold_dat", 32'(TX_P_DATA), 32'(held));
        end
        if (TX_D_VLD && TX_READY) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected actual=0x%0h required=no_byte", TX_P_DATA);
          end else begin
            chk("tx_byte", 32'(TX_P_DATA), 32'(exp_q.pop_front()));
          end
        end
        hold = TX_D_VLD && !TX_READY;
        held = TX_P_DATA;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    RST       = 1'b1;
    RX_P_DATA = 8'h00;
    RX_D_VLD  = 1'b0;
    TX_READY  = 1'b1;
    tick();
    tick();
    chk("rst_alu_a", 32'(ALU_A), 32'h0);
    chk("rst_tx_vld", 32'(TX_D_VLD), 32'h0);
    chk("rst_outputs", {ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, BUSY, OVERRUN, TIMEOUT_ERR}, 32'h0);
    RST = 1'b0;
    tick();

    // ADD 5+3, zero-wait ready: timeline n+1..n+5
    frame(8'h05, 8'h03, 8'h00, 1'b1);
    chk("add_en_n1", 32'(ALU_EN), 32'd1);
    chk("add_busy_n1", 32'(BUSY), 32'd1);
    chk("add_operands", {ALU_A, ALU_B, ALU_FUN}, {12'h0, 8'h05, 8'h03, 4'h0});
    tick();
    chk("add_en_n2", 32'(ALU_EN), 32'd0);
    tick();
    chk("add_lo_n3", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h08});
    tick();
    chk("add_hi_n4", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h00});
    tick();
    chk("add_idle_n5", {BUSY, TX_D_VLD}, 32'h0);

    // MULT FF*FF with ready low for three cycles
    TX_READY = 1'b0;
    frame(8'hFF, 8'hFF, 8'h02, 1'b1);
    tick();
    tick();
    chk("mult_lo_n3", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h01});
    tick();
    tick();
    tick();
    chk("mult_lo_held", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h01});
    TX_READY = 1'b1;
    tick();
    chk("mult_hi", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'hFE});
    wait_idle("mult_idle");

    // NOP frame then SUB 2-1 straight after
    frame(8'h12, 8'h34, 8'h0F, 1'b1);
    chk("nop_no_en", {ALU_EN, BUSY}, 32'h0);
    chk("nop_fun", 32'(ALU_FUN), 32'hF);
    frame(8'h02, 8'h01, 8'h01, 1'b1);
    tick();
    tick();
    chk("sub_lo", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h01});
    wait_idle("sub_idle");

    // Stray byte during SEND_LO
    TX_READY = 1'b0;
    frame(8'h07, 8'h06, 8'h00, 1'b1);
    tick();
    tick();
    send(8'hAA);
    chk("ovr_set", 32'(OVERRUN), 32'd1);
    chk("ovr_lo_kept", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h0D});
    TX_READY = 1'b1;
    wait_idle("ovr_idle");
    chk("ovr_sticky", 32'(OVERRUN), 32'd1);
    chk("ovr_a_kept", 32'(ALU_A), 32'h07);

    // Reset while in SEND_HI
    TX_READY = 1'b0;
    frame(8'h10, 8'h20, 8'h02, 1'b1);
    tick();
    tick();
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
    chk("rsthi_hi_byte", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h02});
    void'(exp_q.pop_front());
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rsthi_tx_vld", 32'(TX_D_VLD), 32'd0);
    chk("rsthi_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA}, 32'h0);
    chk("rsthi_flags", {BUSY, OVERRUN, TIMEOUT_ERR}, 32'h0);
    TX_READY = 1'b1;
    frame(8'h09, 8'h04, 8'h01, 1'b1);
    tick();
    tick();
    chk("fresh_lo", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h05});
    wait_idle("fresh_idle");

    // ALU never answers
    alu_resp_en = 1'b0;
    frame(8'h01, 8'h01, 8'h00, 1'b0);
`ifdef ALU_CTRL_TIMEOUT_EN
    repeat (16) tick();
    chk("tmo_before", {BUSY, TIMEOUT_ERR}, {30'h0, 1'b1, 1'b0});
    tick();
    chk("tmo_after", {BUSY, TIMEOUT_ERR, TX_D_VLD}, {29'h0, 1'b0, 1'b1, 1'b0});
`else
    repeat (20) tick();
    chk("nowdog_busy", {BUSY, TIMEOUT_ERR, TX_D_VLD}, {29'h0, 1'b1, 1'b0, 1'b0});
`endif
    RST = 1'b1;
    tick();
    RST = 1'b0;
    alu_resp_en = 1'b1;
    chk("tmo_rst_clear", {BUSY, TIMEOUT_ERR}, 32'h0);

    // Final MULT 3*4 = 0x000C after recovery
    frame(8'h03, 8'h04, 8'h02, 1'b1);
    tick();
    tick();
    chk("final_lo", {TX_D_VLD, TX_P_DATA}, {23'h0, 1'b1, 8'h0C});
    wait_idle("final_idle");
    tick();
    chk("alu_en_count", 32'(seen_en), 32'(exp_en));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
